// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_req_arbiter_pkg;

    // Which requester currently owns the memory-controller port
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    // addr[17:16] value that selects the I/O region
    localparam logic [1:0] IO_HI_DEF = 2'b11;

    localparam logic [2:0] LS_WORD   = 3'b111;
    localparam logic       MEM_READ  = 1'b0;
    localparam logic       MEM_WRITE = 1'b1;

    // Round-robin pointer encoding: the requester checked first
    localparam logic [1:0] PTR_IF = 2'd0;
    localparam logic [1:0] PTR_LD = 2'd1;
    localparam logic [1:0] PTR_ST = 2'd2;

    // Pointer value that starts the next search just past the winner
    function automatic logic [1:0] ptr_after(input logic [2:0] grant);
        if (grant[0])      return PTR_LD;
        else if (grant[1]) return PTR_ST;
        else               return PTR_IF;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker (bit0=IF, bit1=LD, bit2=ST).
module mem_req_arbiter_rr_pick3
    import mem_req_arbiter_pkg::*;
(
    input  logic [2:0] eligible_i,
    input  logic [1:0] ptr_i,
    input  logic       force_if_i,
    output logic [2:0] grant_o
);

    // Search from ptr_i in IF->LD->ST order unless the starvation guard forces IF
    always_comb begin
        grant_o = 3'b000;
        if (force_if_i && eligible_i[0]) begin
            grant_o = 3'b001;
        end else begin
            case (ptr_i)
                PTR_LD: begin
                    if (eligible_i[1])      grant_o = 3'b010;
                    else if (eligible_i[2]) grant_o = 3'b100;
                    else if (eligible_i[0]) grant_o = 3'b001;
                end
                PTR_ST: begin
                    if (eligible_i[2])      grant_o = 3'b100;
                    else if (eligible_i[0]) grant_o = 3'b001;
                    else if (eligible_i[1]) grant_o = 3'b010;
                end
                default: begin
                    if (eligible_i[0])      grant_o = 3'b001;
                    else if (eligible_i[1]) grant_o = 3'b010;
                    else if (eligible_i[2]) grant_o = 3'b100;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the memory-controller request port among IF fetch, load and store.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int         ADDR_W       = 32,
    parameter int         DATA_W       = 32,
    parameter int         STARVE_LIMIT = 8,
    parameter logic [1:0] IO_HI        = IO_HI_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_type,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [2:0]        st_type,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              mc_enable,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_ls_type,
    output logic [DATA_W-1:0] mc_st_val,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q,      state_d;
    owner_e            owner_q,      owner_d;
    logic [1:0]        rr_ptr_q,     rr_ptr_d;
    logic [CNT_W-1:0]  starve_q,     starve_d;
    logic              mc_enable_q,  mc_enable_d;
    logic              mc_wr_q,      mc_wr_d;
    logic [ADDR_W-1:0] mc_addr_q,    mc_addr_d;
    logic [2:0]        mc_ls_type_q, mc_ls_type_d;
    logic [DATA_W-1:0] mc_st_val_q,  mc_st_val_d;
    logic              if_done_q,    if_done_d;
    logic              ld_done_q,    ld_done_d;
    logic              st_done_q,    st_done_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0] ld_rdata_q,   ld_rdata_d;

    logic              st_io_blocked;
    logic [2:0]        eligible;
    logic              force_if;
    logic [2:0]        grant;

    // Speculative IF/LD requests are masked by flush; I/O stores wait for UART space
    assign st_io_blocked = io_buffer_full && (st_addr[17:16] == IO_HI);
    assign eligible      = {st_req && !st_io_blocked, ld_req && !clr, if_req && !clr};
    assign force_if      = (starve_q >= STARVE_MAX);

    mem_req_arbiter_rr_pick3 u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .force_if_i (force_if),
        .grant_o    (grant)
    );

    // Next-state logic: grant in IDLE, complete or abort in BUSY, swallow completion in DRAIN
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        starve_d     = starve_q;
        mc_enable_d  = mc_enable_q;
        mc_wr_d      = mc_wr_q;
        mc_addr_d    = mc_addr_q;
        mc_ls_type_d = mc_ls_type_q;
        mc_st_val_d  = mc_st_val_q;
        if_done_d    = 1'b0;
        ld_done_d    = 1'b0;
        st_done_d    = 1'b0;
        if_rdata_d   = '0;
        ld_rdata_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|grant) begin
                    state_d     = ARB_BUSY;
                    mc_enable_d = 1'b1;
                    rr_ptr_d    = ptr_after(grant);
                    if (grant[0]) begin
                        owner_d      = OWN_IF;
                        starve_d     = '0;
                        mc_wr_d      = MEM_READ;
                        mc_addr_d    = if_addr;
                        mc_ls_type_d = LS_WORD;
                        mc_st_val_d  = '0;
                    end else begin
                        if (eligible[0] && (starve_q != STARVE_MAX))
                            starve_d = starve_q + 1'b1;
                        if (grant[1]) begin
                            owner_d      = OWN_LD;
                            mc_wr_d      = MEM_READ;
                            mc_addr_d    = ld_addr;
                            mc_ls_type_d = ld_type;
                            mc_st_val_d  = '0;
                        end else begin
                            owner_d      = OWN_ST;
                            mc_wr_d      = MEM_WRITE;
                            mc_addr_d    = st_addr;
                            mc_ls_type_d = st_type;
                            mc_st_val_d  = st_data;
                        end
                    end
                end
            end
            ARB_BUSY: begin
                if (mc_done) begin
                    // No re-grant this cycle: the controller gets a gap between accesses
                    state_d     = ARB_IDLE;
                    owner_d     = OWN_NONE;
                    mc_enable_d = 1'b0;
                    // A flush coinciding with completion still drops speculative results
                    if (!(clr && (owner_q != OWN_ST))) begin
                        case (owner_q)
                            OWN_IF: begin
                                if_done_d  = 1'b1;
                                if_rdata_d = mc_rdata;
                            end
                            OWN_LD: begin
                                ld_done_d  = 1'b1;
                                ld_rdata_d = mc_rdata;
                            end
                            OWN_ST:  st_done_d = 1'b1;
                            default: ;
                        endcase
                    end
                end else if (clr && ((owner_q == OWN_IF) || (owner_q == OWN_LD))) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (mc_done) begin
                    state_d     = ARB_IDLE;
                    owner_d     = OWN_NONE;
                    mc_enable_d = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers; rdy=0 freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_NONE;
            rr_ptr_q     <= PTR_IF;
            starve_q     <= '0;
            mc_enable_q  <= 1'b0;
            mc_wr_q      <= 1'b0;
            mc_addr_q    <= '0;
            mc_ls_type_q <= '0;
            mc_st_val_q  <= '0;
            if_done_q    <= 1'b0;
            ld_done_q    <= 1'b0;
            st_done_q    <= 1'b0;
            if_rdata_q   <= '0;
            ld_rdata_q   <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_q     <= starve_d;
            mc_enable_q  <= mc_enable_d;
            mc_wr_q      <= mc_wr_d;
            mc_addr_q    <= mc_addr_d;
            mc_ls_type_q <= mc_ls_type_d;
            mc_st_val_q  <= mc_st_val_d;
            if_done_q    <= if_done_d;
            ld_done_q    <= ld_done_d;
            st_done_q    <= st_done_d;
            if_rdata_q   <= if_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
        end
    end

    // A completion with no access outstanding is a controller protocol error
    always_ff @(posedge clk) begin
        if (rst_n && rdy && mc_done)
            assert (state_q != ARB_IDLE);
    end

    assign mc_enable  = mc_enable_q;
    assign mc_wr      = mc_wr_q;
    assign mc_addr    = mc_addr_q;
    assign mc_ls_type = mc_ls_type_q;
    assign mc_st_val  = mc_st_val_q;
    assign if_done    = if_done_q;
    assign if_rdata   = if_rdata_q;
    assign ld_done    = ld_done_q;
    assign ld_rdata   = ld_rdata_q;
    assign st_done    = st_done_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (STARVE_LIMIT=2 so the guard is reachable).
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rdy, clr, io_buffer_full;
    logic        if_req, ld_req, st_req;
    logic [31:0] if_addr, ld_addr, st_addr, st_data;
    logic [2:0]  ld_type, st_type;
    logic        if_done, ld_done, st_done;
    logic [31:0] if_rdata, ld_rdata;
    logic        mc_enable, mc_wr, mc_done;
    logic [31:0] mc_addr, mc_st_val, mc_rdata;
    logic [2:0]  mc_ls_type;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2), .IO_HI(2'b11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_type(st_type), .st_data(st_data), .st_done(st_done),
        .mc_enable(mc_enable), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_ls_type(mc_ls_type),
        .mc_st_val(mc_st_val), .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0;
        ld_type = '0; st_type = '0; mc_done = 1'b0; mc_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for a grant, check its fields, complete it after lat cycles, check the done routing
    task automatic serve(input string tag, input int own, input logic [31:0] addr,
                         input logic wr, input logic [2:0] lt, input logic [31:0] sv,
                         input int lat, input logic [31:0] data);
        int n;
        n = 0;
        while (mc_enable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant_wait"}, n, 1);
        chk({tag, "_addr"}, mc_addr, addr);
        chk({tag, "_wr"}, mc_wr, wr);
        chk({tag, "_ls_type"}, mc_ls_type, lt);
        chk({tag, "_st_val"}, mc_st_val, sv);
        if (mc_enable === 1'b1) begin
            repeat (lat - 1) tick();
            mc_done = 1'b1;
            mc_rdata = data;
            tick();
            mc_done = 1'b0;
            mc_rdata = '0;
        end
        chk({tag, "_mc_enable_gap"}, mc_enable, 0);
        chk({tag, "_if_done"}, if_done, (own == 0) ? 1 : 0);
        chk({tag, "_ld_done"}, ld_done, (own == 1) ? 1 : 0);
        chk({tag, "_st_done"}, st_done, (own == 2) ? 1 : 0);
        chk({tag, "_if_rdata"}, if_rdata, (own == 0) ? data : 0);
        chk({tag, "_ld_rdata"}, ld_rdata, (own == 1) ? data : 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_mc_enable", mc_enable, 0);
        chk("rst_mc_addr", mc_addr, 0);
        chk("rst_mc_ls_type", mc_ls_type, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_st_done", st_done, 0);

        // IF only, with rdy low first to show the freeze
        rdy = 1'b0;
        if_addr = 32'h1000;
        if_req = 1'b1;
        tick();
        tick();
        chk("rdy0_no_grant", mc_enable, 0);
        rdy = 1'b1;
        serve("if_only", 0, 32'h1000, 1'b0, 3'b111, 32'h0, 4, 32'hDEAD_BEEF);
        if_req = 1'b0;
        tick();
        chk("if_done_one_cycle", if_done, 0);
        chk("if_rdata_zero", if_rdata, 0);
        chk("if_idle_after", mc_enable, 0);

        // Fairness: all three held, grant order IF, LD, ST, IF
        do_reset();
        if_addr = 32'h100; ld_addr = 32'h2000; ld_type = 3'b010;
        st_addr = 32'h3004; st_type = 3'b001; st_data = 32'hA5A5;
        if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        serve("rr1_if", 0, 32'h100, 1'b0, 3'b111, 32'h0, 3, 32'h11);
        serve("rr2_ld", 1, 32'h2000, 1'b0, 3'b010, 32'h0, 3, 32'h22);
        serve("rr3_st", 2, 32'h3004, 1'b1, 3'b001, 32'hA5A5, 3, 32'h0);
        serve("rr4_if", 0, 32'h100, 1'b0, 3'b111, 32'h0, 3, 32'h44);
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        tick();

        // Starvation: IF loses twice, sits out one LD grant, then must beat ST
        do_reset();
        if_addr = 32'h200; ld_addr = 32'h400; ld_type = 3'b011;
        st_addr = 32'h600; st_type = 3'b111; st_data = 32'h77;
        if_req = 1'b1;
        serve("sv_a_if", 0, 32'h200, 1'b0, 3'b111, 32'h0, 2, 32'h1);
        ld_req = 1'b1; st_req = 1'b1;
        serve("sv_b_ld", 1, 32'h400, 1'b0, 3'b011, 32'h0, 2, 32'h2);
        ld_req = 1'b0;
        serve("sv_c_st", 2, 32'h600, 1'b1, 3'b111, 32'h77, 2, 32'h0);
        if_req = 1'b0; st_req = 1'b0; ld_req = 1'b1;
        serve("sv_d_ld", 1, 32'h400, 1'b0, 3'b011, 32'h0, 2, 32'h3);
        ld_req = 1'b0; if_req = 1'b1; st_req = 1'b1;
        serve("sv_e_if_forced", 0, 32'h200, 1'b0, 3'b111, 32'h0, 2, 32'h4);
        if_req = 1'b0; st_req = 1'b0;
        tick();

        // Flush mid-load: access continues, completion swallowed
        do_reset();
        ld_addr = 32'h40; ld_type = 3'b010; ld_req = 1'b1;
        tick();
        chk("fl_ld_grant", mc_enable, 1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ld_req = 1'b0;
        chk("fl_ld_enable_held1", mc_enable, 1);
        tick();
        chk("fl_ld_enable_held2", mc_enable, 1);
        mc_done = 1'b1;
        mc_rdata = 32'hBAD0_BAD0;
        tick();
        mc_done = 1'b0;
        mc_rdata = '0;
        chk("fl_ld_no_done", ld_done, 0);
        chk("fl_ld_no_rdata", ld_rdata, 0);
        chk("fl_ld_enable_drop", mc_enable, 0);
        if_addr = 32'h880; if_req = 1'b1;
        serve("fl_ld_then_if", 0, 32'h880, 1'b0, 3'b111, 32'h0, 2, 32'h5);
        if_req = 1'b0;

        // Flush mid-store: store still completes; pending IF not granted during flush
        do_reset();
        st_addr = 32'h80; st_type = 3'b100; st_data = 32'h1234; st_req = 1'b1;
        if_addr = 32'h900;
        tick();
        chk("fl_st_grant", mc_enable, 1);
        clr = 1'b1;
        if_req = 1'b1;
        tick();
        clr = 1'b0;
        chk("fl_st_enable_held", mc_enable, 1);
        chk("fl_st_owner_kept", mc_addr, 32'h80);
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        chk("fl_st_done", st_done, 1);
        chk("fl_st_if_done_quiet", if_done, 0);
        st_req = 1'b0;
        serve("fl_st_then_if", 0, 32'h900, 1'b0, 3'b111, 32'h0, 2, 32'h6);
        if_req = 1'b0;
        // Flush in IDLE blocks only that cycle's IF grant
        tick();
        if_req = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_idle_blocks_if", mc_enable, 0);
        serve("clr_idle_then_if", 0, 32'h900, 1'b0, 3'b111, 32'h0, 2, 32'h7);
        if_req = 1'b0;

        // I/O backpressure: LD goes first, store waits for UART space
        do_reset();
        st_addr = 32'h30000; st_type = 3'b111; st_data = 32'h55; st_req = 1'b1;
        ld_addr = 32'h500; ld_type = 3'b010; ld_req = 1'b1;
        io_buffer_full = 1'b1;
        serve("io_ld_first", 1, 32'h500, 1'b0, 3'b010, 32'h0, 3, 32'h8);
        ld_req = 1'b0;
        repeat (6) tick();
        chk("io_store_held", mc_enable, 0);
        io_buffer_full = 1'b0;
        serve("io_store", 2, 32'h30000, 1'b1, 3'b111, 32'h55, 2, 32'h0);
        st_req = 1'b0;

        // Asynchronous reset while BUSY
        if_addr = 32'hA00; if_req = 1'b1;
        tick();
        tick();
        chk("arst_pre_busy", mc_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_mc_enable", mc_enable, 0);
        chk("arst_mc_addr", mc_addr, 0);
        chk("arst_mc_ls_type", mc_ls_type, 0);
        if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
